param_updown_mod_counter: RTL



---
 rtl/param_updown_mod_counter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/param_updown_mod_counter.sv
// Parametrised synchronous up/down modulo counter.
// Provides a parallel load with clamping, wrap or saturate at the range ends,
// a clock-enable prescaler, a terminal-count flag, and wrap pulse/sticky flags.
// An "event" is a step taken while terminal_count is high. Saturated holds
// count as events too.
module param_updown_mod_counter #(
  parameter int                WIDTH    = 4,
  parameter longint unsigned   MODULUS  = 16,
  parameter int                SATURATE = 0,
  parameter int                PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] count,
  output logic             terminal_count,
  output logic             wrap_pulse,
  output logic             wrap_sticky
);

  // Largest reachable count. When MODULUS is 2**WIDTH this is all ones, and
  // the load clamp can then never trigger.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  // The prescaler keeps at least one bit so that PRESCALE=1 still elaborates.
  // In that case the bit stays at zero, and every enabled cycle is a step.
  localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]    prescale_r;
  logic [PW-1:0]    prescale_nxt_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] step_value_s;
  logic [WIDTH-1:0] load_clamped_s;
  logic             event_s;

  // The terminal count depends on the direction that is currently requested.
  assign terminal_count = up_down ? (count == MAX_VAL) : (count == {WIDTH{1'b0}});

  // Compute the count after one step in the requested direction.
  // At a range end, the count either wraps or holds.
  always_comb begin
    step_value_s = count;
    if (up_down) begin
      if (count == MAX_VAL) begin
        if (SATURATE != 0) begin
          step_value_s = count;
        end else begin
          step_value_s = {WIDTH{1'b0}};
        end
      end else begin
        step_value_s = count + WIDTH'(1'b1);
      end
    end else begin
      if (count == {WIDTH{1'b0}}) begin
        if (SATURATE != 0) begin
          step_value_s = count;
        end else begin
          step_value_s = MAX_VAL;
        end
      end else begin
        step_value_s = count - WIDTH'(1'b1);
      end
    end
  end

  // Clamp an out-of-range load value to the top of the count range.
  always_comb begin
    load_clamped_s = load_value;
    if (load_value > MAX_VAL) begin
      load_clamped_s = MAX_VAL;
    end else begin
      load_clamped_s = load_value;
    end
  end

  // Next-state selection, in priority order: load, then enabled step, then hold.
  // Load bypasses enable, zeroes the prescaler and never raises an event.
  always_comb begin
    count_nxt_s    = count;
    prescale_nxt_s = prescale_r;
    event_s        = 1'b0;
    if (load) begin
      count_nxt_s    = load_clamped_s;
      prescale_nxt_s = {PW{1'b0}};
    end else if (enable) begin
      if (prescale_r == PS_MAX) begin
        prescale_nxt_s = {PW{1'b0}};
        count_nxt_s    = step_value_s;
        event_s        = terminal_count;
      end else begin
        prescale_nxt_s = prescale_r + PW'(1'b1);
      end
    end else begin
      count_nxt_s    = count;
      prescale_nxt_s = prescale_r;
    end
  end

  // State and flag registers. Reset overrides everything on its edge.
  // On a simultaneous event and clear_flag, the sticky flag is set.
  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= {WIDTH{1'b0}};
      prescale_r  <= {PW{1'b0}};
      wrap_pulse  <= 1'b0;
      wrap_sticky <= 1'b0;
    end else begin
      count       <= count_nxt_s;
      prescale_r  <= prescale_nxt_s;
      wrap_pulse  <= event_s;
      wrap_sticky <= (wrap_sticky & ~clear_flag) | event_s;
    end
  end

endmodule
